// File: rtl/stream_pkg.sv
// Shared types for the stream packet router: packet FSM states and drop counter width.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/stream_out_slot.sv
// One-entry output beat register with valid/ready; loads on the same edge it drains.
module stream_out_slot #(
  parameter int DW = 8,
  parameter int QW = 4,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  input  logic [QW-1:0] i_qos,
  input  logic          i_last,
  input  logic [IW-1:0] i_dest,
  output logic          o_in_rdy,
  input  logic          i_out_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_data,
  output logic [QW-1:0] o_qos,
  output logic          o_last,
  output logic [IW-1:0] o_dest
);

  logic          r_vld;
  logic [DW-1:0] r_data;
  logic [QW-1:0] r_qos;
  logic          r_last;
  logic [IW-1:0] r_dest;

  assign o_in_rdy = !r_vld || i_out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_qos  <= '0;
      r_last <= 1'b0;
      r_dest <= '0;
    end else if (i_vld && o_in_rdy) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
      r_qos  <= i_qos;
      r_last <= i_last;
      r_dest <= i_dest;
    end else if (i_out_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_qos  = r_qos;
  assign o_last = r_last;
  assign o_dest = r_dest;

endmodule

// File: rtl/stream_packet_router.sv
// Routes packets to one of STREAM_COUNT outputs by the id on their first beat; bad ids are dropped and counted.
// One cycle input-to-output latency through a single shared output slot.
module stream_packet_router
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_in,
  input  logic [T_QOS__WIDTH-1:0] s_qos_in,
  input  logic [T_ID___WIDTH-1:0] s_id_in,
  input  logic                    s_last_in,
  input  logic                    s_valid_in,
  output logic                    s_ready_out,
  output logic [T_DATA_WIDTH-1:0] m_data_out [STREAM_COUNT],
  output logic [T_QOS__WIDTH-1:0] m_qos_out  [STREAM_COUNT],
  output logic [STREAM_COUNT-1:0] m_last_out,
  output logic [STREAM_COUNT-1:0] m_valid_out,
  input  logic [STREAM_COUNT-1:0] m_ready_in,
  output logic [DROP_CNT_W-1:0]   drop_cnt_out
);

  localparam logic [T_ID___WIDTH:0] ID_LIMIT = STREAM_COUNT[T_ID___WIDTH:0];

  state_t                  r_state;
  logic [T_ID___WIDTH-1:0] r_dest;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  logic                    w_id_ok;
  logic                    w_accept;
  logic                    w_fwd;
  logic [T_ID___WIDTH-1:0] w_fwd_dest;
  logic                    w_slot_in_rdy;
  logic                    w_slot_out_rdy;
  logic                    w_slot_vld;
  logic [T_DATA_WIDTH-1:0] w_slot_data;
  logic [T_QOS__WIDTH-1:0] w_slot_qos;
  logic                    w_slot_last;
  logic [T_ID___WIDTH-1:0] w_slot_dest;
  logic [STREAM_COUNT-1:0] w_hit;

  assign w_id_ok     = {1'b0, s_id_in} < ID_LIMIT;
  assign s_ready_out = rst || (r_state == DROP) || w_slot_in_rdy;
  assign w_accept    = s_valid_in && s_ready_out;
  assign w_fwd       = s_valid_in && (((r_state == IDLE) && w_id_ok) || (r_state == FWD));
  assign w_fwd_dest  = (r_state == FWD) ? r_dest : s_id_in;

  stream_out_slot #(
    .DW(T_DATA_WIDTH),
    .QW(T_QOS__WIDTH),
    .IW(T_ID___WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (w_fwd),
    .i_data    (s_data_in),
    .i_qos     (s_qos_in),
    .i_last    (s_last_in),
    .i_dest    (w_fwd_dest),
    .o_in_rdy  (w_slot_in_rdy),
    .i_out_rdy (w_slot_out_rdy),
    .o_vld     (w_slot_vld),
    .o_data    (w_slot_data),
    .o_qos     (w_slot_qos),
    .o_last    (w_slot_last),
    .o_dest    (w_slot_dest)
  );

  // Destination is latched on the first beat and ignored until the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dest     <= '0;
      r_drop_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (w_id_ok) begin
            r_dest  <= s_id_in;
            r_state <= s_last_in ? IDLE : FWD;
          end else begin
            if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
              r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
            r_state <= s_last_in ? IDLE : DROP;
          end
        end
        FWD, DROP: begin
          if (s_last_in) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_hit          = '0;
    w_slot_out_rdy = 1'b0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (w_slot_dest == T_ID___WIDTH'(i)) begin
        w_hit[i]       = w_slot_vld && !rst;
        w_slot_out_rdy = m_ready_in[i];
      end
    end
  end

  // Non-selected streams present all-zero beats.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      m_valid_out[i] = w_hit[i];
      m_data_out[i]  = w_hit[i] ? w_slot_data : '0;
      m_qos_out[i]   = w_hit[i] ? w_slot_qos : '0;
      m_last_out[i]  = w_hit[i] && w_slot_last;
    end
  end

  assign drop_cnt_out = rst ? '0 : r_drop_cnt;

endmodule

// File: tb/tb_stream_packet_router.sv
// Randomized plus directed bench for stream_packet_router with a queue-based scoreboard and packet-level model.
module tb_stream_packet_router;

  localparam int DW = 8;
  localparam int QW = 4;
  localparam int SC = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data_in;
  logic [QW-1:0] s_qos_in;
  logic [IW-1:0] s_id_in;
  logic          s_last_in;
  logic          s_valid_in;
  logic          s_ready_out;
  logic [DW-1:0] m_data_out [SC];
  logic [QW-1:0] m_qos_out  [SC];
  logic [SC-1:0] m_last_out;
  logic [SC-1:0] m_valid_out;
  logic [SC-1:0] m_ready_in;
  logic [15:0]   drop_cnt_out;

  always #5 clk = ~clk;

  stream_packet_router #(
    .T_DATA_WIDTH(DW),
    .T_QOS__WIDTH(QW),
    .STREAM_COUNT(SC),
    .T_ID___WIDTH(IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data_in    (s_data_in),
    .s_qos_in     (s_qos_in),
    .s_id_in      (s_id_in),
    .s_last_in    (s_last_in),
    .s_valid_in   (s_valid_in),
    .s_ready_out  (s_ready_out),
    .m_data_out   (m_data_out),
    .m_qos_out    (m_qos_out),
    .m_last_out   (m_last_out),
    .m_valid_out  (m_valid_out),
    .m_ready_in   (m_ready_in),
    .drop_cnt_out (drop_cnt_out)
  );

  typedef struct {
    int            dest;
    logic [DW-1:0] d;
    logic [QW-1:0] q;
    logic          l;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Packet-level reference state
  bit    in_pkt    = 0;
  bit    dropping  = 0;
  int    cur_dest  = 0;
  int    exp_drop  = 0;
  bit    lat_pend  = 0;
  int    lat_dest  = 0;
  bit    rand_done = 0;
  logic [SC-1:0] prev_stall = '0;
  logic [13:0]   prev_out [SC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept();
    beat_t b;
    if (!in_pkt) begin
      if (int'(s_id_in) < SC) begin
        cur_dest = int'(s_id_in);
        dropping = 0;
      end else begin
        dropping = 1;
        if (exp_drop < 65535) exp_drop++;
      end
    end
    if (!dropping) begin
      b.dest = cur_dest;
      b.d = s_data_in;
      b.q = s_qos_in;
      b.l = s_last_in;
      sb.push_back(b);
      lat_pend = 1;
      lat_dest = cur_dest;
    end
    in_pkt = !s_last_in;
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      chk("rst_valid", 64'(m_valid_out), 64'd0);
      chk("rst_ready", 64'(s_ready_out), 64'd1);
      chk("rst_drop", 64'(drop_cnt_out), 64'd0);
      for (int i = 0; i < SC; i++)
        chk("rst_zero", 64'({m_data_out[i], m_qos_out[i], m_last_out[i]}), 64'd0);
      sb.delete();
      in_pkt = 0;
      dropping = 0;
      exp_drop = 0;
      lat_pend = 0;
      prev_stall = '0;
    end else begin
      chk("onehot", 64'($countones(m_valid_out) <= 1), 64'd1);
      if (lat_pend) chk("latency", 64'(m_valid_out), 64'd1 << lat_dest);
      for (int i = 0; i < SC; i++) begin
        if (!m_valid_out[i])
          chk("idle_zero", 64'({m_data_out[i], m_qos_out[i], m_last_out[i]}), 64'd0);
        if (prev_stall[i])
          chk("hold", 64'({m_valid_out[i], m_data_out[i], m_qos_out[i], m_last_out[i]}), 64'(prev_out[i]));
        if (m_valid_out[i] && m_ready_in[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: stream %0d data %0h, none expected", i, m_data_out[i]);
          end else begin
            b = sb.pop_front();
            chk("beat_dest", 64'(i), 64'(b.dest));
            chk("beat_content", 64'({m_data_out[i], m_qos_out[i], m_last_out[i]}), 64'({b.d, b.q, b.l}));
          end
        end
        prev_stall[i] = m_valid_out[i] && !m_ready_in[i];
        prev_out[i] = {m_valid_out[i], m_data_out[i], m_qos_out[i], m_last_out[i]};
      end
      chk("drop_cnt", 64'(drop_cnt_out), 64'(exp_drop));
      if (in_pkt && dropping) chk("drop_ready", 64'(s_ready_out), 64'd1);
      lat_pend = 0;
      if (s_valid_in && s_ready_out) model_accept();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [QW-1:0] q,
                      input logic l, output int waits);
    s_valid_in = 1'b1;
    s_id_in = id;
    s_data_in = d;
    s_qos_in = q;
    s_last_in = l;
    waits = 0;
    @(negedge clk);
    while (!s_ready_out && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!s_ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready_out %0b required 1 within 200 cycles", s_ready_out);
    end
    @(posedge clk);
    #1;
    s_valid_in = 1'b0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w0, w1, w2;
    int len, id;
    rst = 1'b1;
    s_valid_in = 1'b0;
    s_data_in = '0;
    s_qos_in = '0;
    s_id_in = '0;
    s_last_in = 1'b0;
    m_ready_in = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Single-beat packet to stream 1
    send(2'd1, 8'h5A, 4'd3, 1'b1, w);
    chk("single_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(m_valid_out), 64'b10);
    chk("single_data", 64'(m_data_out[1]), 64'h5A);
    chk("single_qos", 64'(m_qos_out[1]), 64'd3);
    chk("single_last", 64'(m_last_out[1]), 64'd1);
    step();

    // Three beats to stream 0; later-beat ids must be ignored
    send(2'd0, 8'h11, 4'd1, 1'b0, w0);
    send(2'd1, 8'h22, 4'd2, 1'b0, w1);
    send(2'd1, 8'h33, 4'd0, 1'b1, w2);
    chk("b2b_waits", 64'(w0 + w1 + w2), 64'd0);
    m_ready_in = '1;
    repeat (2) step();

    // Output stall on stream 0 mid-packet
    m_ready_in = 2'b10;
    send(2'd0, 8'h44, 4'd5, 1'b0, w);
    chk("stall_first_wait", 64'(w), 64'd0);
    fork
      send(2'd0, 8'h55, 4'd6, 1'b1, w);
      begin
        repeat (4) @(posedge clk);
        #1 m_ready_in = 2'b11;
      end
    join
    chk("stall_wait", 64'(w), 64'd4);
    repeat (2) step();

    // Stalled stream 0 blocks a packet for stream 1
    m_ready_in = 2'b10;
    send(2'd0, 8'h66, 4'd1, 1'b1, w);
    chk("block_first_wait", 64'(w), 64'd0);
    fork
      send(2'd1, 8'h77, 4'd2, 1'b1, w);
      begin
        repeat (3) @(posedge clk);
        #1 m_ready_in = 2'b11;
      end
    join
    chk("block_wait", 64'(w), 64'd3);
    repeat (2) step();

    // Two-beat drop packet
    send(2'd3, 8'hA1, 4'd1, 1'b0, w0);
    send(2'd3, 8'hA2, 4'd2, 1'b1, w1);
    chk("drop_waits", 64'(w0 + w1), 64'd0);
    @(negedge clk);
    chk("drop_one", 64'(drop_cnt_out), 64'd1);
    chk("drop_novalid", 64'(m_valid_out), 64'd0);
    step();

    // Reset mid-packet, then a fresh packet to stream 1
    send(2'd0, 8'h88, 4'd1, 1'b0, w);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", 64'(m_valid_out), 64'd0);
    step();
    send(2'd1, 8'h99, 4'd4, 1'b1, w);
    @(negedge clk);
    chk("post_rst_route", 64'(m_valid_out), 64'b10);
    chk("post_rst_data", 64'(m_data_out[1]), 64'h99);
    step();

    // Randomized traffic with random output backpressure
    fork
      begin
        for (int p = 0; p < 300; p++) begin
          len = $urandom_range(1, 4);
          id = $urandom_range(0, 3);
          for (int k = 0; k < len; k++) begin
            send((k == 0) ? IW'(id) : IW'($urandom_range(0, 3)), DW'($urandom), QW'($urandom),
                 (k == len - 1), w);
            if ($urandom_range(0, 3) == 0) step();
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_ready_in = SC'($urandom_range(0, 3));
        end
      end
    join
    m_ready_in = '1;
    repeat (3) step();

    // Drop counter saturation
    for (int k = 0; k < 65536; k++) send(2'd3, DW'(k), 4'd0, 1'b1, w);
    @(negedge clk);
    chk("drop_saturate", 64'(drop_cnt_out), 64'hFFFF);
    step();
    repeat (3) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_packet_router.md
STREAM_PACKET_ROUTER -- requirements
Module: stream_packet_router

Interface
REQ-001 Parameter T_DATA_WIDTH, default 8, beat data width.
REQ-002 Parameter T_QOS__WIDTH, default 4, QoS tag width.
REQ-003 Parameter STREAM_COUNT, default 2, number of output streams (>=2).
REQ-004 Parameter T_ID___WIDTH, default $clog2(STREAM_COUNT), destination id width.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 s_data_in  input  T_DATA_WIDTH  input beat data.
REQ-008 s_qos_in  input  T_QOS__WIDTH  input QoS tag.
REQ-009 s_id_in  input  T_ID___WIDTH  destination stream index.
REQ-010 s_last_in  input  1  last beat of packet.
REQ-011 s_valid_in / s_ready_out  input / output  1 each  input handshake.
REQ-012 m_data_out[STREAM_COUNT]  output  T_DATA_WIDTH each  per-stream data.
REQ-013 m_qos_out[STREAM_COUNT]  output  T_QOS__WIDTH each  per-stream QoS.
REQ-014 m_last_out, m_valid_out, m_ready_in  output, output, input  STREAM_COUNT  per-stream last/valid/ready.
REQ-015 drop_cnt_out  output  16  saturating count of dropped packets.

Function
REQ-016 Input beat SHALL transfer when s_valid_in && s_ready_out at a rising clk edge; output beat i SHALL transfer when m_valid_out[i] && m_ready_in[i].
REQ-017 Destination SHALL be sampled from s_id_in on the first beat of a packet only and held until the beat with s_last_in=1 is accepted; s_id_in SHALL be ignored on later beats.
REQ-018 FSM states: IDLE (expect first beat), FWD (mid-packet, routing to locked dest), DROP (mid-packet, discarding).
REQ-019 IDLE: accepted first beat with s_id_in < STREAM_COUNT -> beat forwarded; next state FWD if s_last_in=0, else IDLE.
REQ-020 IDLE: accepted first beat with s_id_in >= STREAM_COUNT -> beat discarded; drop_cnt_out increments by 1 (saturating at 16'hFFFF); next state DROP if s_last_in=0, else IDLE.
REQ-021 FWD/DROP: accepted beat with s_last_in=1 SHALL return FSM to IDLE.
REQ-022 Output SHALL use a single registered beat slot (data, qos, last, dest); latency from input accept to m_valid_out[dest]=1 is exactly 1 cycle.
REQ-023 At most one m_valid_out bit SHALL be high in any cycle; m_data_out/m_qos_out/m_last_out of non-valid streams SHALL be 0.
REQ-024 s_ready_out SHALL be 1 in DROP; otherwise s_ready_out = !slot_valid || m_ready_in[slot_dest] (combinational, full 1 beat/cycle throughput).
REQ-025 Simultaneous slot drain and input accept SHALL reload the slot in the same edge with no bubble.
REQ-026 A stalled output beat (m_ready_in low) SHALL hold m_data_out, m_qos_out, m_last_out and m_valid_out stable until accepted.
REQ-027 A new packet to a different destination SHALL NOT be accepted while the slot holds an unaccepted beat for another stream.
REQ-028 QoS and last SHALL pass through unmodified, including qos=0.

Reset
REQ-029 While rst=1: FSM=IDLE, slot empty, all m_valid_out=0, all m_data_out/m_qos_out/m_last_out=0, drop_cnt_out=0, s_ready_out=1.
REQ-030 Reset mid-packet SHALL abandon the packet; the first beat accepted after rst deasserts SHALL be treated as a packet start.

Structure
REQ-031 Shared package stream_pkg SHALL hold the FSM state enum (IDLE, FWD, DROP) and the drop counter width constant (16).
REQ-032 The output slot SHALL be a sub-module stream_out_slot (one-entry register with valid/ready, dest field).
REQ-033 Implementation SHALL be synthesizable, no latches, 120-400 lines total.

Verification
REQ-034 Single-beat packet id=1, data=0x5A, qos=3, last=1, m_ready_in all 1 -> next cycle m_valid_out=2'b10, m_data_out[1]=0x5A, m_qos_out[1]=3, m_last_out[1]=1.
REQ-035 3-beat packet id=0, s_id_in changed to 1 on beats 2-3 -> all 3 beats on stream 0, last only on beat 3, back-to-back 1 beat/cycle.
REQ-036 m_ready_in[0]=0 for 4 cycles during 2-beat packet to stream 0 -> s_ready_out=0 after slot fills, m_data_out[0] stable, no beat lost or duplicated after release.
REQ-037 Packet id=3 (STREAM_COUNT=2), 2 beats -> s_ready_out=1 both beats, no m_valid_out, drop_cnt_out 0->1; 65536 such packets -> drop_cnt_out=16'hFFFF.
REQ-038 Packet to stream 0 stalled in slot, next packet to stream 1 presented -> s_ready_out=0 until stream 0 beat accepted, then stream 1 beat appears 1 cycle after its accept.
REQ-039 rst=1 for 1 cycle mid-packet (FWD) -> outputs zero next cycle; subsequent beat with id=1 routes to stream 1.
